// File: rtl/riscv_pkg.sv
// Shared core definitions used by the MEM-stage load/store unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP
    } lsu_state_t;

    localparam logic [31:0] TRAP_CODE_LOAD_ADDR_MISALIGNED  = 32'd4;
    localparam logic [31:0] TRAP_CODE_STORE_ADDR_MISALIGNED = 32'd6;

    // Byte accesses can never be misaligned, so only half/word sizes are inputs.
    function automatic logic lsu_misaligned(input logic [1:0] off, input logic half, input logic word);
        return (half & off[0]) | (word & (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic        st_byte_i,
    input  logic        st_half_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_b_i,
    input  logic        ld_bu_i,
    input  logic        ld_h_i,
    input  logic        ld_hu_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        st_wstrb_o = 4'b1111;
        st_wdata_o = st_wdata_i;
        if (st_byte_i) begin
            st_wstrb_o = 4'b0001 << st_off_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
        end else if (st_half_i) begin
            st_wstrb_o = 4'b0011 << st_off_i;
            st_wdata_o = {2{st_wdata_i[15:0]}};
        end
    end

    always_comb begin
        ld_shift  = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = ld_shift;
        if (ld_b_i)       ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
        else if (ld_bu_i) ld_data_o = {24'h0, ld_shift[7:0]};
        else if (ld_h_i)  ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
        else if (ld_hu_i) ld_data_o = {16'h0, ld_shift[15:0]};
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/response FSM, misalignment traps and pipeline stall.
module mem_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_start_i,
    input  logic        lsu_is_read_i,
    input  logic        lsu_is_write_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_size_b_i,
    input  logic        lsu_size_bu_i,
    input  logic        lsu_size_h_i,
    input  logic        lsu_size_hu_i,
    input  logic        lsu_size_w_i,
    input  logic        lsu_flush_i,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_req_addr_o,
    output logic        dmem_req_we_o,
    output logic [3:0]  dmem_req_wstrb_o,
    output logic [31:0] dmem_req_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rsp_rdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_load_data_o,
    output logic        lsu_trap_valid_o,
    output logic [31:0] lsu_trap_mcause_o,
    output logic [31:0] lsu_trap_addr_o
);

    lsu_state_t  state_q, state_d;
    logic        drop_q, drop_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  ld_sz_q, ld_sz_d;   // {b, bu, h, hu}; all zero means word
    logic        done_q, done_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        trap_q, trap_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    logic        misaligned;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_fmt;

    assign misaligned = lsu_misaligned(lsu_addr_i[1:0], lsu_size_h_i | lsu_size_hu_i, lsu_size_w_i);

    lsu_align u_align (
        .st_off_i   (lsu_addr_i[1:0]),
        .st_byte_i  (lsu_size_b_i | lsu_size_bu_i),
        .st_half_i  (lsu_size_h_i | lsu_size_hu_i),
        .st_wdata_i (lsu_wdata_i),
        .st_wstrb_o (st_wstrb),
        .st_wdata_o (st_wdata),
        .ld_off_i   (off_q),
        .ld_b_i     (ld_sz_q[3]),
        .ld_bu_i    (ld_sz_q[2]),
        .ld_h_i     (ld_sz_q[1]),
        .ld_hu_i    (ld_sz_q[0]),
        .ld_rdata_i (dmem_rsp_rdata_i),
        .ld_data_o  (ld_fmt)
    );

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_addr_d  = req_addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        ld_sz_d     = ld_sz_q;
        done_d      = 1'b0;
        ld_data_d   = ld_data_q;
        trap_d      = 1'b0;
        mcause_d    = mcause_q;
        trap_addr_d = trap_addr_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (lsu_start_i && !lsu_flush_i) begin
                    if (misaligned) begin
                        trap_d      = 1'b1;
                        mcause_d    = lsu_is_read_i ? TRAP_CODE_LOAD_ADDR_MISALIGNED
                                                    : TRAP_CODE_STORE_ADDR_MISALIGNED;
                        trap_addr_d = lsu_addr_i;
                    end else begin
                        state_d    = LSU_REQ;
                        drop_d     = 1'b0;
                        req_addr_d = {lsu_addr_i[31:2], 2'b00};
                        we_d       = lsu_is_write_i;
                        wstrb_d    = lsu_is_write_i ? st_wstrb : 4'b0000;
                        wdata_d    = st_wdata;
                        off_d      = lsu_addr_i[1:0];
                        ld_sz_d    = {lsu_size_b_i, lsu_size_bu_i, lsu_size_h_i, lsu_size_hu_i};
                    end
                end
            end
            LSU_REQ: begin
                // An accepted request must still be drained even if flushed in the same cycle.
                if (dmem_req_ready_i) begin
                    state_d = LSU_WAIT_RSP;
                    drop_d  = lsu_flush_i;
                end else if (lsu_flush_i) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT_RSP: begin
                if (lsu_flush_i) drop_d = 1'b1;
                if (dmem_rsp_valid_i) begin
                    state_d = LSU_IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !lsu_flush_i) begin
                        done_d = 1'b1;
                        if (!we_q) ld_data_d = ld_fmt;
                    end
                end
            end
            default: state_d = LSU_IDLE;
        endcase
        req_valid_d = (state_d == LSU_REQ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LSU_IDLE;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            off_q       <= 2'b00;
            ld_sz_q     <= 4'h0;
            done_q      <= 1'b0;
            ld_data_q   <= 32'h0;
            trap_q      <= 1'b0;
            mcause_q    <= 32'h0;
            trap_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            ld_sz_q     <= ld_sz_d;
            done_q      <= done_d;
            ld_data_q   <= ld_data_d;
            trap_q      <= trap_d;
            mcause_q    <= mcause_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign lsu_busy_o        = (state_q != LSU_IDLE) | (lsu_start_i & ~misaligned);
    assign dmem_req_valid_o  = req_valid_q;
    assign dmem_req_addr_o   = req_addr_q;
    assign dmem_req_we_o     = we_q;
    assign dmem_req_wstrb_o  = wstrb_q;
    assign dmem_req_wdata_o  = wdata_q;
    assign lsu_done_o        = done_q;
    assign lsu_load_data_o   = ld_data_q;
    assign lsu_trap_valid_o  = trap_q;
    assign lsu_trap_mcause_o = mcause_q;
    assign lsu_trap_addr_o   = trap_addr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a transaction-level reference model and per-cycle compare.
module tb_mem_lsu;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        lsu_start_i = 0, lsu_is_read_i = 0, lsu_is_write_i = 0;
    logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0;
    logic        lsu_size_b_i = 0, lsu_size_bu_i = 0, lsu_size_h_i = 0, lsu_size_hu_i = 0, lsu_size_w_i = 0;
    logic        lsu_flush_i = 0;
    logic        dmem_req_valid_o, dmem_req_ready_i = 0, dmem_req_we_o;
    logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
    logic [3:0]  dmem_req_wstrb_o;
    logic        dmem_rsp_valid_i = 0;
    logic [31:0] dmem_rsp_rdata_i = 0;
    logic        lsu_busy_o, lsu_done_o, lsu_trap_valid_o;
    logic [31:0] lsu_load_data_o, lsu_trap_mcause_o, lsu_trap_addr_o;

    mem_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_start_i(lsu_start_i), .lsu_is_read_i(lsu_is_read_i), .lsu_is_write_i(lsu_is_write_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_size_b_i(lsu_size_b_i), .lsu_size_bu_i(lsu_size_bu_i), .lsu_size_h_i(lsu_size_h_i),
        .lsu_size_hu_i(lsu_size_hu_i), .lsu_size_w_i(lsu_size_w_i), .lsu_flush_i(lsu_flush_i),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_we_o(dmem_req_we_o),
        .dmem_req_wstrb_o(dmem_req_wstrb_o), .dmem_req_wdata_o(dmem_req_wdata_o),
        .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_load_data_o(lsu_load_data_o),
        .lsu_trap_valid_o(lsu_trap_valid_o), .lsu_trap_mcause_o(lsu_trap_mcause_o),
        .lsu_trap_addr_o(lsu_trap_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Size codes: 0=b 1=bu 2=h 3=hu 4=w
    function automatic logic [31:0] m_load(input int sz, input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (sz)
            0: return (v[7:0] >= 8'd128) ? 32'(int'(v[7:0]) - 256) : 32'(v[7:0]);
            1: return v & 32'hFF;
            2: return (v[15:0] >= 16'd32768) ? 32'(int'(v[15:0]) - 65536) : 32'(v[15:0]);
            3: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // Expected per-op schedule, in absolute cycle numbers
    bit          cmp_en = 0;
    int          e_busy_from = 0, e_busy_to = 0, e_req_from = 1, e_req_to = 0, e_done = -1, e_trap = -1;
    logic [31:0] e_addr, e_wdata, e_ld, e_mcause, e_taddr;
    logic [3:0]  e_wstrb;
    logic        e_we, e_load;
    logic [31:0] m_ld = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          last_done = -1, op_c0 = 0;

    always @(negedge clk_i) begin
        if (lsu_done_o) last_done = cyc;
        if (cmp_en) begin
            if (e_load && cyc == e_done) m_ld = e_ld;
            chk("busy", 32'(lsu_busy_o), 32'(cyc >= e_busy_from && cyc < e_busy_to));
            chk("req_valid", 32'(dmem_req_valid_o), 32'(cyc >= e_req_from && cyc <= e_req_to));
            if (dmem_req_valid_o) begin
                chk("req_addr", dmem_req_addr_o, e_addr);
                chk("req_we", 32'(dmem_req_we_o), 32'(e_we));
                chk("req_wstrb", 32'(dmem_req_wstrb_o), 32'(e_wstrb));
                if (e_we) chk("req_wdata", dmem_req_wdata_o, e_wdata);
                cap_addr = dmem_req_addr_o; cap_wdata = dmem_req_wdata_o; cap_wstrb = dmem_req_wstrb_o;
            end
            chk("done", 32'(lsu_done_o), 32'(cyc == e_done));
            chk("trap_valid", 32'(lsu_trap_valid_o), 32'(cyc == e_trap));
            if (lsu_trap_valid_o) begin
                chk("trap_mcause", lsu_trap_mcause_o, e_mcause);
                chk("trap_addr", lsu_trap_addr_o, e_taddr);
            end
            chk("load_data", lsu_load_data_o, m_ld);
        end
    end

    task automatic op(input int sz, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int rdly, input int rspd, input bit flush_w);
        bit mis;
        int rsp_cyc;
        @(posedge clk_i); #1;
        op_c0 = cyc;
        mis = ((sz == 2 || sz == 3) && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
        e_addr = addr & ~32'h3; e_we = wr; e_load = !wr && !flush_w;
        e_wstrb = !wr ? 4'h0 : (sz <= 1) ? 4'(1 << (addr % 4)) : (sz <= 3) ? 4'(3 << (addr % 4)) : 4'hF;
        e_wdata = (sz <= 1) ? wd[7:0] * 32'h01010101 : (sz <= 3) ? wd[15:0] * 32'h00010001 : wd;
        e_ld = m_load(sz, addr[1:0], rd);
        e_mcause = wr ? 32'd6 : 32'd4; e_taddr = addr;
        e_busy_from = op_c0;
        if (mis) begin
            e_busy_to = op_c0; e_req_from = 1; e_req_to = 0; e_done = -1; e_trap = op_c0 + 1;
        end else begin
            rsp_cyc = op_c0 + 2 + rdly + rspd;
            e_req_from = op_c0 + 1; e_req_to = op_c0 + 1 + rdly; e_trap = -1;
            e_busy_to = rsp_cyc + 1; e_done = flush_w ? -1 : rsp_cyc + 1;
        end
        lsu_start_i = 1; lsu_is_read_i = !wr; lsu_is_write_i = wr; lsu_addr_i = addr; lsu_wdata_i = wd;
        {lsu_size_b_i, lsu_size_bu_i, lsu_size_h_i, lsu_size_hu_i, lsu_size_w_i} = 5'(5'b10000 >> sz);
        @(posedge clk_i); #1;
        lsu_start_i = 0;
        if (mis) begin
            @(posedge clk_i); #1;
            return;
        end
        dmem_req_ready_i = (rdly == 0);
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk_i); #1;
            dmem_req_ready_i = (i == rdly - 1);
        end
        @(posedge clk_i); #1;
        dmem_req_ready_i = 0; lsu_flush_i = flush_w;
        for (int i = 0; i < rspd; i++) begin
            @(posedge clk_i); #1;
            lsu_flush_i = 0;
        end
        dmem_rsp_valid_i = 1; dmem_rsp_rdata_i = rd;
        @(posedge clk_i); #1;
        dmem_rsp_valid_i = 0; lsu_flush_i = 0; dmem_rsp_rdata_i = $urandom;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req_valid", 32'(dmem_req_valid_o), 32'h0);
        chk("rst_busy", 32'(lsu_busy_o), 32'h0);
        chk("rst_load_data", lsu_load_data_o, 32'h0);
        chk("rst_trap", 32'(lsu_trap_valid_o), 32'h0);
        rst_ni = 1; cmp_en = 1;

        op(4, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
        chk("lw_addr_lit", cap_addr, 32'h100);
        chk("lw_wstrb_lit", 32'(cap_wstrb), 32'h0);
        chk("lw_done_lat", 32'(last_done - op_c0), 32'd3);
        chk("lw_data_lit", lsu_load_data_o, 32'hDEADBEEF);
        op(0, 0, 32'h103, 0, 32'h80112233, 0, 0, 0);
        chk("lb_lit", lsu_load_data_o, 32'hFFFFFF80);
        op(1, 0, 32'h103, 0, 32'h80112233, 0, 0, 0);
        chk("lbu_lit", lsu_load_data_o, 32'h00000080);
        op(3, 0, 32'h102, 0, 32'h80112233, 0, 0, 0);
        chk("lhu_lit", lsu_load_data_o, 32'h00008011);
        op(0, 1, 32'h201, 32'h000000AB, $urandom, 0, 0, 0);
        chk("sb_addr_lit", cap_addr, 32'h200);
        chk("sb_wstrb_lit", 32'(cap_wstrb), 32'h2);
        chk("sb_wdata_lit", cap_wdata, 32'hABABABAB);
        chk("store_keeps_ld", lsu_load_data_o, 32'h00008011);
        op(2, 1, 32'h202, 32'h1234CAFE, $urandom, 0, 1, 0);
        chk("sh_wstrb_lit", 32'(cap_wstrb), 32'hC);
        chk("sh_wdata_lit", cap_wdata, 32'hCAFECAFE);
        op(2, 0, 32'h101, 0, 0, 0, 0, 0);
        op(4, 1, 32'h102, 32'h55, 0, 0, 0, 0);
        op(4, 0, 32'h300, 0, 32'h13579BDF, 3, 2, 0);
        chk("slow_done_lat", 32'(last_done - op_c0), 32'd8);
        op(4, 0, 32'h304, 0, 32'hFFFF0000, 0, 1, 1);
        chk("flush_keeps_ld", lsu_load_data_o, 32'h13579BDF);
        op(2, 0, 32'h102, 0, 32'h80001234, 1, 0, 0);
        chk("lh_lit", lsu_load_data_o, 32'hFFFF8000);

        // Asynchronous reset while a request is pending
        cmp_en = 0;
        @(posedge clk_i); #1;
        lsu_start_i = 1; lsu_is_read_i = 1; lsu_is_write_i = 0; lsu_addr_i = 32'h400;
        {lsu_size_b_i, lsu_size_bu_i, lsu_size_h_i, lsu_size_hu_i, lsu_size_w_i} = 5'b00001;
        dmem_req_ready_i = 0;
        @(posedge clk_i); #1;
        lsu_start_i = 0;
        chk("pre_rst_req", 32'(dmem_req_valid_o), 32'h1);
        #2 rst_ni = 0; #1;
        chk("arst_req_valid", 32'(dmem_req_valid_o), 32'h0);
        chk("arst_req_addr", dmem_req_addr_o, 32'h0);
        chk("arst_busy", 32'(lsu_busy_o), 32'h0);
        chk("arst_load_data", lsu_load_data_o, 32'h0);
        chk("arst_done", 32'(lsu_done_o), 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        m_ld = 0; e_busy_to = 0; e_req_from = 1; e_req_to = 0; e_done = -1; e_trap = -1;
        cmp_en = 1;
        op(4, 0, 32'h500, 0, 32'h0BADF00D, 0, 0, 0);
        chk("post_rst_lw", lsu_load_data_o, 32'h0BADF00D);
        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit in the MEM stage of the 5-stage RV32I core. It consumes the execute stage's registered memory-access controls (address from the ALU/CSR result, store data, size flags) and drives the data-memory request/response bus. It performs byte-lane alignment and load sign/zero extension, raises misaligned-access traps, and stalls the pipeline while a bus transaction is in flight.

## Interface
- No parameters; XLEN fixed at 32.
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- lsu_start_i  in  1  valid MEM-stage memory op: mem_q_valid & (read|write) & ~upstream trap
- lsu_is_read_i / lsu_is_write_i  in  1 each  op type; exactly one is set when lsu_start_i is high
- lsu_addr_i  in  32  byte address (mem_q_alu_csr_result)
- lsu_wdata_i  in  32  store data (mem_q_store_wdata)
- lsu_size_b_i, lsu_size_bu_i, lsu_size_h_i, lsu_size_hu_i, lsu_size_w_i  in  1 each  access size, one-hot
- lsu_flush_i  in  1  kill the in-flight op (trap/redirect younger than WB)
- dmem_req_valid_o  out  1  request valid
- dmem_req_ready_i  in  1  request accepted
- dmem_req_addr_o  out  32  word address, bits [1:0] = 0
- dmem_req_we_o  out  1  1 = store
- dmem_req_wstrb_o  out  4  byte enables; 0000 for loads
- dmem_req_wdata_o  out  32  lane-aligned store data
- dmem_rsp_valid_i  in  1  response/ack valid, one cycle
- dmem_rsp_rdata_i  in  32  raw read word
- lsu_busy_o  out  1  stall IF..MEM this cycle
- lsu_done_o  out  1  one-cycle pulse: op completed
- lsu_load_data_o  out  32  extended load result, held until next done
- lsu_trap_valid_o  out  1  one-cycle misaligned-access trap pulse
- lsu_trap_mcause_o  out  32  4 = load misaligned, 6 = store misaligned
- lsu_trap_addr_o  out  32  faulting byte address (mtval)

## Operation
- States: IDLE, REQ, WAIT_RSP.
- IDLE, lsu_start_i, aligned: latch addr, we, wstrb, wdata, size and addr[1:0]; go REQ.
- IDLE, lsu_start_i, misaligned (h/hu with addr[0]=1; w with addr[1:0]!=0): no bus request. Next cycle trap_valid=1 with mcause and trap_addr; stay IDLE. b/bu are never misaligned.
- REQ: dmem_req_valid_o=1, payload held stable. Handshake on valid&ready goes to WAIT_RSP. Valid never drops before ready.
- WAIT_RSP: on dmem_rsp_valid_i, register the formatted load data (loads only; stores leave lsu_load_data_o unchanged), pulse lsu_done_o next cycle, go IDLE. Stores also wait for the ack.
- Store lanes: sb gives strb = 0001<<off, data = {4{wdata[7:0]}}. sh gives strb = 0011<<off, data = {2{wdata[15:0]}}. sw gives strb = 1111.
- Load extract: shift rdata right by 8*off, then take the byte or half. b/h sign-extend, bu/hu zero-extend, w passes through.
- lsu_busy_o = (state != IDLE) | (lsu_start_i & aligned). It is low in the done and trap cycles.
- Flush in IDLE or REQ before the handshake: go IDLE, no transaction, no done.
- Flush in WAIT_RSP: set a drop flag. The response is still absorbed, then the unit goes IDLE with no done and load data unchanged. busy stays high until the response arrives.
- lsu_start_i outside IDLE is ignored; the pipeline is stalled by busy.
- Reset, including mid-transaction: state IDLE, drop flag cleared, every output 0 (load data 0).

## Timing
- Zero-wait bus (ready=1, rsp one cycle after accept): start at cycle 0, req_valid at 1, rsp at 2, done at 3.
- Each ready-low cycle adds one cycle. Each response-delay cycle adds one cycle.
- Trap pulse appears 1 cycle after start.
- All outputs except lsu_busy_o are registered.
- No combinational path from dmem_*_i to dmem_*_o.

## Structure
- riscv_pkg additions:
  - lsu_state_t enum
  - TRAP_CODE_LOAD_ADDR_MISALIGNED = 4
  - TRAP_CODE_STORE_ADDR_MISALIGNED = 6
- One combinational sub-module, lsu_align: store strobe and wdata generation, load extract and extend.
- FSM and registers live in mem_lsu.

## Test plan
- lw, addr 0x100, rsp 0xDEADBEEF, ready=1 -> req_addr 0x100, wstrb 0000, done at cycle 3, load data 0xDEADBEEF.
- lb, addr 0x103, rdata 0x80112233 -> load data 0xFFFFFF80. lbu at the same address -> 0x00000080. lhu, addr 0x102 -> 0x00008011.
- sb, addr 0x201, wdata 0x000000AB -> addr 0x200, wstrb 0010, wdata 0xABABABAB. sh, addr 0x202 -> wstrb 1100.
- lh at 0x101 -> no req_valid; trap 1 cycle later, mcause 4, trap_addr 0x101. sw at 0x102 -> mcause 6.
- ready low 3 cycles, then rsp 2 cycles later -> payload stable throughout, busy high until done, done at cycle 8.
- Flush during WAIT_RSP, then rsp arrives -> no done, load data unchanged. Reset asserted in REQ -> all outputs 0 asynchronously, state IDLE.
